// File: rtl/lcd12864_text_ctrl.sv
// ST7920 (LCD12864) character-mode controller: timed power-up, init commands, then an
// endless refresh of a ROWS x COLS text buffer over the write-only 8-bit parallel bus.
module lcd12864_text_ctrl #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int EN_CYC       = 25,
  parameter int CMD_WAIT_CYC = 4000,
  parameter int CLR_WAIT_CYC = 80000,
  parameter int PWRUP_CYC    = 2_000_000,
  parameter int ROWS         = 4,
  parameter int COLS         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_row,
  input  logic [3:0] wr_col,
  input  logic [7:0] wr_data,
  output logic [7:0] lcd_dat,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       ready,
  output logic       frame_done
);
  localparam int MAX_A   = (PWRUP_CYC > CLR_WAIT_CYC) ? PWRUP_CYC : CLR_WAIT_CYC;
  localparam int MAX_B   = (EN_CYC > CMD_WAIT_CYC) ? EN_CYC : CMD_WAIT_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int NCELL   = ROWS * COLS;

  if (CLK_HZ <= 0 || ROWS < 1 || ROWS > 4 || COLS < 1 || COLS > 16) begin : g_bad_param
    $error("lcd12864_text_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {S_PWRUP, S_INIT, S_ROW_ADDR, S_ROW_CHAR} state_t;
  typedef enum logic [1:0] {P_SETUP, P_PULSE, P_WAIT} phase_t;

  state_t          state_q, state_d;
  phase_t          phase_q, phase_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      init_idx_q, init_idx_d;
  logic [1:0]      row_q, row_d;
  logic [3:0]      col_q, col_d;
  logic [7:0]      dat_q, dat_d;
  logic            rs_q, rs_d;
  logic            en_q, en_d;
  logic            ready_q, ready_d;
  logic            fd_q, fd_d;
  logic [7:0]      buf_q [NCELL];
  logic [7:0]      buf_d [NCELL];

  logic            wr_ok;
  logic [5:0]      wr_idx;
  logic [5:0]      rd_idx;
  logic [7:0]      rd_char;
  logic            wait_last;
  logic            load;
  logic [7:0]      ld_dat;
  logic            ld_rs;

  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    case (i)
      3'd0, 3'd1: init_cmd = 8'h30;
      3'd2:       init_cmd = 8'h0C;
      3'd3:       init_cmd = 8'h01;
      default:    init_cmd = 8'h06;
    endcase
  endfunction

  // ST7920 DDRAM row origins are interleaved: rows 2/3 continue rows 0/1.
  function automatic logic [7:0] row_cmd(input logic [1:0] r);
    case (r)
      2'd0:    row_cmd = 8'h80;
      2'd1:    row_cmd = 8'h90;
      2'd2:    row_cmd = 8'h88;
      default: row_cmd = 8'h98;
    endcase
  endfunction

  always_comb begin
    wr_ok  = wr_en && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
    wr_idx = 6'(wr_row) * 6'(COLS) + 6'(wr_col);
    rd_idx = 6'(row_q) * 6'(COLS);
    if (state_q == S_ROW_CHAR) rd_idx = rd_idx + 6'(col_q) + 6'd1;
    rd_char = 8'h20;
    for (int i = 0; i < NCELL; i++) begin
      if (rd_idx == 6'(i)) rd_char = buf_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    init_idx_d = init_idx_q;
    row_d      = row_q;
    col_d      = col_q;
    dat_d      = dat_q;
    rs_d       = rs_q;
    en_d       = en_q;
    ready_d    = ready_q;
    fd_d       = 1'b0;
    buf_d      = buf_q;
    load       = 1'b0;
    ld_dat     = dat_q;
    ld_rs      = rs_q;
    wait_last  = (!rs_q && dat_q == 8'h01) ? (cnt_q == CW'(CLR_WAIT_CYC - 1))
                                           : (cnt_q == CW'(CMD_WAIT_CYC - 1));

    for (int i = 0; i < NCELL; i++) begin
      if (wr_ok && wr_idx == 6'(i)) buf_d[i] = wr_data;
    end

    if (state_q == S_PWRUP) begin
      if (cnt_q == CW'(PWRUP_CYC - 1)) begin
        state_d    = S_INIT;
        init_idx_d = 3'd0;
        load       = 1'b1;
        ld_dat     = init_cmd(3'd0);
        ld_rs      = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      case (phase_q)
        P_SETUP: begin
          phase_d = P_PULSE;
          en_d    = 1'b1;
          cnt_d   = '0;
        end
        P_PULSE: begin
          if (cnt_q == CW'(EN_CYC - 1)) begin
            phase_d = P_WAIT;
            en_d    = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        P_WAIT: begin
          if (wait_last) begin
            load = 1'b1;
            case (state_q)
              S_INIT: begin
                ld_rs = 1'b0;
                if (init_idx_q == 3'd4) begin
                  ready_d = 1'b1;
                  state_d = S_ROW_ADDR;
                  row_d   = 2'd0;
                  ld_dat  = row_cmd(2'd0);
                end else begin
                  init_idx_d = init_idx_q + 3'd1;
                  ld_dat     = init_cmd(init_idx_q + 3'd1);
                end
              end
              S_ROW_ADDR: begin
                state_d = S_ROW_CHAR;
                col_d   = 4'd0;
                ld_dat  = rd_char;
                ld_rs   = 1'b1;
              end
              S_ROW_CHAR: begin
                if (col_q == 4'(COLS - 1)) begin
                  state_d = S_ROW_ADDR;
                  ld_rs   = 1'b0;
                  if (row_q == 2'(ROWS - 1)) begin
                    fd_d   = 1'b1;
                    row_d  = 2'd0;
                    ld_dat = row_cmd(2'd0);
                  end else begin
                    row_d  = row_q + 2'd1;
                    ld_dat = row_cmd(row_q + 2'd1);
                  end
                end else begin
                  col_d  = col_q + 4'd1;
                  ld_dat = rd_char;
                  ld_rs  = 1'b1;
                end
              end
              default: state_d = S_PWRUP;
            endcase
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: phase_d = P_SETUP;
      endcase
    end

    // The next byte is latched here, so a same-cycle buffer write only shows next frame.
    if (load) begin
      phase_d = P_SETUP;
      cnt_d   = '0;
      dat_d   = ld_dat;
      rs_d    = ld_rs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_PWRUP;
      phase_q    <= P_SETUP;
      cnt_q      <= '0;
      init_idx_q <= 3'd0;
      row_q      <= 2'd0;
      col_q      <= 4'd0;
      dat_q      <= 8'h00;
      rs_q       <= 1'b0;
      en_q       <= 1'b0;
      ready_q    <= 1'b0;
      fd_q       <= 1'b0;
      for (int i = 0; i < NCELL; i++) buf_q[i] <= 8'h20;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      init_idx_q <= init_idx_d;
      row_q      <= row_d;
      col_q      <= col_d;
      dat_q      <= dat_d;
      rs_q       <= rs_d;
      en_q       <= en_d;
      ready_q    <= ready_d;
      fd_q       <= fd_d;
      buf_q      <= buf_d;
    end
  end

  assign lcd_dat    = dat_q;
  assign lcd_rs     = rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_en     = en_q;
  assign ready      = ready_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_lcd12864_text_ctrl.sv
// Directed bench: a 2x3 and a 4x16 instance with short delays; bytes are captured on each
// lcd_en rise and compared against hand-computed tables of commands, data and cycle numbers.
`timescale 1ns/1ps
module tb_lcd12864_text_ctrl;
  localparam int EN = 2, CMDW = 4, CLRW = 8, PWR = 10;

  typedef struct {logic rs; logic [7:0] dat; int rise; int hi;} byte_t;
  typedef struct {logic rs; logic [7:0] dat; int rise;} vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, a_wr_en, a_rs, a_rw, a_en, a_rdy, a_fd;
  logic [1:0] a_wr_row;
  logic [3:0] a_wr_col;
  logic [7:0] a_wr_data, a_dat;
  logic       rst_b, b_wr_en, b_rs, b_rw, b_en, b_rdy, b_fd;
  logic [1:0] b_wr_row;
  logic [3:0] b_wr_col;
  logic [7:0] b_wr_data, b_dat;

  lcd12864_text_ctrl #(.EN_CYC(EN), .CMD_WAIT_CYC(CMDW), .CLR_WAIT_CYC(CLRW),
                       .PWRUP_CYC(PWR), .ROWS(2), .COLS(3)) u_a (
    .clk(clk), .rst_n(rst_a), .wr_en(a_wr_en), .wr_row(a_wr_row), .wr_col(a_wr_col),
    .wr_data(a_wr_data), .lcd_dat(a_dat), .lcd_rs(a_rs), .lcd_rw(a_rw), .lcd_en(a_en),
    .ready(a_rdy), .frame_done(a_fd));

  lcd12864_text_ctrl #(.EN_CYC(EN), .CMD_WAIT_CYC(CMDW), .CLR_WAIT_CYC(CLRW),
                       .PWRUP_CYC(PWR), .ROWS(4), .COLS(16)) u_b (
    .clk(clk), .rst_n(rst_b), .wr_en(b_wr_en), .wr_row(b_wr_row), .wr_col(b_wr_col),
    .wr_data(b_wr_data), .lcd_dat(b_dat), .lcd_rs(b_rs), .lcd_rw(b_rw), .lcd_en(b_en),
    .ready(b_rdy), .frame_done(b_fd));

  int n_chk = 0, n_err = 0;
  int cyc_a, cyc_b;
  byte_t qa[$], qb[$];
  int fd_a[$];
  int rdy_a = -1, rdy_b = -1, rdy_drop_a = 0;
  int viol_a = 0, viol_b = 0;
  logic       a_en_p = 1'b0, a_rs_p = 1'b0, a_rdy_p = 1'b0;
  logic       b_en_p = 1'b0, b_rs_p = 1'b0, b_rdy_p = 1'b0;
  logic [7:0] a_dat_p = 8'h00, b_dat_p = 8'h00;

  always @(posedge clk or negedge rst_a) if (!rst_a) cyc_a <= 0; else cyc_a <= cyc_a + 1;
  always @(posedge clk or negedge rst_b) if (!rst_b) cyc_b <= 0; else cyc_b <= cyc_b + 1;

  // Byte capture: rs/dat must already be stable the cycle before EN rises and while EN is high.
  always @(negedge clk) begin
    byte_t nb;
    if (rst_a) begin
      if (a_en && !a_en_p) begin
        if (a_dat !== a_dat_p || a_rs !== a_rs_p) viol_a++;
        nb = '{a_rs, a_dat, cyc_a, 0};
        qa.push_back(nb);
      end
      if (a_en && qa.size() > 0) begin
        qa[qa.size()-1].hi = qa[qa.size()-1].hi + 1;
        if (qa[qa.size()-1].dat !== a_dat || qa[qa.size()-1].rs !== a_rs) viol_a++;
      end
      if (a_fd) fd_a.push_back(cyc_a);
      if (a_rdy && !a_rdy_p) rdy_a = cyc_a;
      if (!a_rdy && a_rdy_p) rdy_drop_a++;
    end
    a_en_p = rst_a & a_en; a_rs_p = a_rs; a_dat_p = a_dat; a_rdy_p = rst_a & a_rdy;
  end

  always @(negedge clk) begin
    byte_t nb;
    if (rst_b) begin
      if (b_en && !b_en_p) begin
        if (b_dat !== b_dat_p || b_rs !== b_rs_p) viol_b++;
        nb = '{b_rs, b_dat, cyc_b, 0};
        qb.push_back(nb);
      end
      if (b_en && qb.size() > 0) begin
        qb[qb.size()-1].hi = qb[qb.size()-1].hi + 1;
        if (qb[qb.size()-1].dat !== b_dat || qb[qb.size()-1].rs !== b_rs) viol_b++;
      end
      if (b_rdy && !b_rdy_p) rdy_b = cyc_b;
    end
    b_en_p = rst_b & b_en; b_rs_p = b_rs; b_dat_p = b_dat; b_rdy_p = rst_b & b_rdy;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h (%0d), want 0x%0h (%0d)", nm, act, act, exp, exp);
    end
  endtask

  function automatic byte_t at_a(input int i);
    byte_t d = '{1'b1, 8'hFF, -1, -1};
    if (i < qa.size()) d = qa[i];
    return d;
  endfunction

  function automatic byte_t at_b(input int i);
    byte_t d = '{1'b1, 8'hFF, -1, -1};
    if (i < qb.size()) d = qb[i];
    return d;
  endfunction

  task automatic chk_byte(input string nm, input byte_t g, input vec_t e);
    chk({nm, "_rs_dat"}, int'({g.rs, g.dat}), int'({e.rs, e.dat}));
    chk({nm, "_rise"}, g.rise, e.rise);
    chk({nm, "_en_hi"}, g.hi, EN);
  endtask

  task automatic wr_a(input logic [1:0] r, input logic [3:0] c, input logic [7:0] d);
    a_wr_en = 1'b1; a_wr_row = r; a_wr_col = c; a_wr_data = d;
    @(negedge clk);
    a_wr_en = 1'b0;
  endtask

  // Expected 4x16 frame f (0-based from ready) byte j; race_val lands at row0/col5 in frame 1.
  function automatic vec_t exp_b(input int f, input int j, input logic [7:0] race_val);
    logic [7:0] row_addr [4] = '{8'h80, 8'h90, 8'h88, 8'h98};
    vec_t v;
    if (j % 17 == 0) v = '{1'b0, row_addr[j / 17], 50 + 7 * (68 * f + j)};
    else             v = '{1'b1, 8'h20, 50 + 7 * (68 * f + j)};
    if (f == 1 && j == 6) v.dat = race_val;
    return v;
  endfunction

  vec_t       tab_a [21];
  vec_t       tab_init [5];
  logic [7:0] frame_a [8];

  initial begin
    tab_init = '{'{1'b0, 8'h30, 11}, '{1'b0, 8'h30, 18}, '{1'b0, 8'h0C, 25},
                 '{1'b0, 8'h01, 32}, '{1'b0, 8'h06, 43}};
    frame_a  = '{8'h80, 8'h41, 8'h42, 8'h43, 8'h90, 8'h78, 8'h79, 8'h7A};
    for (int i = 0; i < 5; i++) tab_a[i] = tab_init[i];
    for (int n = 0; n < 16; n++) tab_a[5+n] = '{(n % 4) != 0, frame_a[n % 8], 50 + 7 * n};

    rst_a = 1'b0; rst_b = 1'b0;
    a_wr_en = 1'b0; a_wr_row = 2'd0; a_wr_col = 4'd0; a_wr_data = 8'h00;
    b_wr_en = 1'b0; b_wr_row = 2'd0; b_wr_col = 4'd0; b_wr_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("a_reset_outputs", int'({a_dat, a_rs, a_rw, a_en, a_rdy, a_fd}), 0);
    chk("b_reset_outputs", int'({b_dat, b_rs, b_rw, b_en, b_rdy, b_fd}), 0);

    // 2x3 instance: back-to-back writes during power-up, then out-of-range writes mid-frame.
    rst_a = 1'b1;
    wr_a(2'd0, 4'd0, 8'h41); wr_a(2'd0, 4'd1, 8'h42); wr_a(2'd0, 4'd2, 8'h43);
    wr_a(2'd1, 4'd0, 8'h78); wr_a(2'd1, 4'd1, 8'h79); wr_a(2'd1, 4'd2, 8'h7A);
    while (cyc_a < 60) @(negedge clk);
    wr_a(2'd3, 4'd2, 8'h51); wr_a(2'd0, 4'd15, 8'h51); wr_a(2'd0, 4'd3, 8'h51);
    wr_a(2'd2, 4'd0, 8'h51); wr_a(2'd1, 4'd3, 8'h51);
    while (cyc_a < 175) @(negedge clk);
    for (int i = 0; i < 21; i++) chk_byte($sformatf("a_byte%0d", i), at_a(i), tab_a[i]);
    chk("a_ready_rise_cycle", rdy_a, 49);
    chk("a_ready_drops", rdy_drop_a, 0);
    chk("a_frame_done_count", fd_a.size(), 2);
    chk("a_frame_done_1", (fd_a.size() > 0) ? fd_a[0] : -1, 105);
    chk("a_frame_done_2", (fd_a.size() > 1) ? fd_a[1] : -1, 161);
    chk("a_bus_stability", viol_a, 0);

    // 4x16 instance: write racing the SETUP of row0/col5, then reset mid row-2 data byte.
    rst_b = 1'b1;
    while (cyc_b < 91) @(negedge clk);
    chk("b_race_setup_bus", int'({b_en, b_rs, b_dat}), int'({1'b0, 1'b1, 8'h20}));
    b_wr_en = 1'b1; b_wr_row = 2'd0; b_wr_col = 4'd5; b_wr_data = 8'h41;
    @(negedge clk);
    b_wr_en = 1'b0;
    while (cyc_b < 771) @(negedge clk);
    for (int i = 0; i < 5; i++) chk_byte($sformatf("b_init%0d", i), at_b(i), tab_init[i]);
    for (int j = 0; j < 68; j++) chk_byte($sformatf("b_f0_byte%0d", j), at_b(5 + j), exp_b(0, j, 8'h41));
    for (int j = 0; j < 35; j++) chk_byte($sformatf("b_f1_byte%0d", j), at_b(73 + j), exp_b(1, j, 8'h41));
    chk("b_pre_reset_en", int'(b_en), 1);
    chk("b_pre_reset_row2_char", int'({b_rs, b_dat}), int'({1'b1, 8'h20}));
    rst_b = 1'b0;
    #1;
    chk("b_async_reset_en_ready", int'({b_en, b_rdy, b_fd}), 0);
    chk("b_async_reset_bus", int'({b_rs, b_dat}), 0);
    repeat (3) @(negedge clk);
    qb.delete();
    rdy_b = -1;
    rst_b = 1'b1;
    while (cyc_b < 530) @(negedge clk);
    for (int i = 0; i < 5; i++) chk_byte($sformatf("b_reinit%0d", i), at_b(i), tab_init[i]);
    for (int j = 0; j < 68; j++) chk_byte($sformatf("b_re_f0_byte%0d", j), at_b(5 + j), exp_b(0, j, 8'h20));
    chk("b_re_ready_rise_cycle", rdy_b, 49);
    chk("b_bus_stability", viol_b, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err + 1);
    $fatal(1, "watchdog");
  end
endmodule
